// File: rtl/carfield_pkg.sv
// Shared types and constants for the Carfield L2 port arbiter.
package carfield_pkg;

    // Target selected by an incoming request address.
    typedef enum logic [1:0] {
        PORT0  = 2'd0,
        PORT1  = 2'd1,
        DECERR = 2'd2
    } port_sel_e;

    localparam logic [63:0] L2_BASE_DEFAULT = 64'h0000_0000_7800_0000;
    localparam logic [63:0] L2_SIZE_DEFAULT = 64'h0000_0000_0020_0000;

    // Map an address onto one of the two back-to-back L2 windows.
    function automatic port_sel_e decode_port(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] size
    );
        logic [63:0] end0_s;
        logic [63:0] end1_s;
        port_sel_e   sel_s;
        end0_s = base + size;
        end1_s = end0_s + size;
        if ((addr >= base) && (addr < end0_s)) begin
            sel_s = PORT0;
        end else if ((addr >= end0_s) && (addr < end1_s)) begin
            sel_s = PORT1;
        end else begin
            sel_s = DECERR;
        end
        return sel_s;
    endfunction

endpackage

// File: rtl/carfield_l2_port_sched.sv
// Per-port scheduler: round-robin pick among eligible requesters plus an
// in-order FIFO of granted requester IDs used to route responses back.
module carfield_l2_port_sched #(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned IdW      = 1,
    parameter int unsigned MaxOutst = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] elig_i,
    input  logic              gnt_i,
    input  logic              rvalid_i,
    output logic              req_o,
    output logic [IdW-1:0]    win_idx_o,
    output logic [NumReq-1:0] win_onehot_o,
    output logic              full_o,
    output logic              pop_valid_o,
    output logic [IdW-1:0]    pop_id_o
);

    localparam int unsigned PtrW  = $clog2(MaxOutst);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned CandW = IdW + 1;

    logic [IdW-1:0]                rr_ptr_r;
    logic [MaxOutst-1:0][IdW-1:0]  fifo_r;
    logic [PtrW-1:0]               wr_ptr_r;
    logic [PtrW-1:0]               rd_ptr_r;
    logic [CntW-1:0]               count_r;

    logic                          win_found_s;
    logic [IdW-1:0]                win_idx_s;
    logic [CandW-1:0]              cand_s;
    logic [CandW-1:0]              rr_nxt_s;
    logic                          push_s;
    logic                          pop_s;

    // Round-robin search starting at the pointer, wrapping at NumReq.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IdW{1'b0}};
        cand_s      = {CandW{1'b0}};
        for (int k = 0; k < int'(NumReq); k++) begin
            cand_s = {1'b0, rr_ptr_r} + CandW'(k);
            if (cand_s >= CandW'(NumReq)) begin
                cand_s = cand_s - CandW'(NumReq);
            end else begin
                cand_s = cand_s;
            end
            if (!win_found_s && elig_i[cand_s[IdW-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s[IdW-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next pointer is one past the winner, wrapping to zero.
    always_comb begin
        rr_nxt_s = {1'b0, win_idx_s} + {{(CandW-1){1'b0}}, 1'b1};
        if (rr_nxt_s >= CandW'(NumReq)) begin
            rr_nxt_s = {CandW{1'b0}};
        end else begin
            rr_nxt_s = rr_nxt_s;
        end
    end

    // Grant/response handshakes; a response with nothing queued is ignored.
    always_comb begin
        push_s       = win_found_s & gnt_i;
        pop_s        = rvalid_i & (count_r != {CntW{1'b0}});
        req_o        = win_found_s;
        win_idx_o    = win_idx_s;
        full_o       = (count_r == CntW'(MaxOutst));
        pop_valid_o  = pop_s;
        pop_id_o     = fifo_r[rd_ptr_r];
        if (win_found_s) begin
            win_onehot_o = {{(NumReq-1){1'b0}}, 1'b1} << win_idx_s;
        end else begin
            win_onehot_o = {NumReq{1'b0}};
        end
    end

    // Pointer advances only when the L2 port accepts the winner.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_r <= {IdW{1'b0}};
        end else if (push_s) begin
            rr_ptr_r <= rr_nxt_s[IdW-1:0];
        end
    end

    // ID FIFO storage and occupancy tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fifo_r   <= {(MaxOutst*IdW){1'b0}};
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CntW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= win_idx_s;
                wr_ptr_r         <= wr_ptr_r + {{(PtrW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PtrW-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CntW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CntW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/carfield_l2_port_arb.sv
// Arbitrates NumReq requesters onto two L2 ports selected by address window,
// routing in-order responses back and answering unmapped addresses locally.
module carfield_l2_port_arb
    import carfield_pkg::*;
#(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned MaxOutst  = 4,
    parameter logic [63:0] L2Base    = L2_BASE_DEFAULT,
    parameter logic [63:0] L2Size    = L2_SIZE_DEFAULT
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NumReq-1:0]                      req_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]       addr_i,
    input  logic [NumReq-1:0]                      we_i,
    input  logic [NumReq-1:0][DataWidth-1:0]       wdata_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]     be_i,
    output logic [NumReq-1:0]                      gnt_o,
    output logic [NumReq-1:0]                      rvalid_o,
    output logic [NumReq-1:0][DataWidth-1:0]       rdata_o,
    output logic [NumReq-1:0]                      err_o,
    output logic [1:0]                             l2_req_o,
    output logic [1:0][AddrWidth-1:0]              l2_addr_o,
    output logic [1:0]                             l2_we_o,
    output logic [1:0][DataWidth-1:0]              l2_wdata_o,
    output logic [1:0][DataWidth/8-1:0]            l2_be_o,
    input  logic [1:0]                             l2_gnt_i,
    input  logic [1:0]                             l2_rvalid_i,
    input  logic [1:0][DataWidth-1:0]              l2_rdata_i
);

    localparam int unsigned BeWidth   = DataWidth / 8;
    localparam int unsigned IdW       = $clog2(NumReq);
    localparam int unsigned CntW      = $clog2(MaxOutst) + 1;
    localparam logic [63:0] Port1Base = L2Base + L2Size;

    port_sel_e                      sel_s [NumReq];
    logic [NumReq-1:0][AddrWidth-1:0] off_s;
    logic [1:0][NumReq-1:0]         elig_s;
    logic [NumReq-1:0]              dec_gnt_s;
    logic [1:0]                     port_req_s;
    logic [1:0][IdW-1:0]            win_idx_s;
    logic [1:0][NumReq-1:0]         win_oh_s;
    logic [1:0]                     full_s;
    logic [1:0]                     pop_valid_s;
    logic [1:0][IdW-1:0]            pop_id_s;
    logic [1:0][NumReq-1:0]         port_gnt_s;
    logic [1:0][NumReq-1:0]         resp_hit_s;
    logic [NumReq-1:0]              out_inc_s;
    logic [NumReq-1:0]              out_dec_s;

    logic [NumReq-1:0][CntW-1:0]    outst_r;
    logic [NumReq-1:0]              last_port_r;
    logic [NumReq-1:0]              err_pend_r;

    // Address decode and window-relative offset per requester.
    always_comb begin
        off_s = {(NumReq*AddrWidth){1'b0}};
        for (int i = 0; i < int'(NumReq); i++) begin
            sel_s[i] = decode_port(64'(addr_i[i]), L2Base, L2Size);
            case (sel_s[i])
                PORT0:   off_s[i] = AddrWidth'(64'(addr_i[i]) - L2Base);
                PORT1:   off_s[i] = AddrWidth'(64'(addr_i[i]) - Port1Base);
                default: off_s[i] = {AddrWidth{1'b0}};
            endcase
        end
    end

    // Eligibility: a requester may only talk to one port at a time, and
    // unmapped requests are answered locally once nothing is in flight.
    always_comb begin
        elig_s    = {(2*NumReq){1'b0}};
        dec_gnt_s = {NumReq{1'b0}};
        for (int i = 0; i < int'(NumReq); i++) begin
            elig_s[0][i] = !rst_i && req_i[i] && (sel_s[i] == PORT0) && !full_s[0] &&
                           ((outst_r[i] == {CntW{1'b0}}) || !last_port_r[i]);
            elig_s[1][i] = !rst_i && req_i[i] && (sel_s[i] == PORT1) && !full_s[1] &&
                           ((outst_r[i] == {CntW{1'b0}}) || last_port_r[i]);
            dec_gnt_s[i] = !rst_i && req_i[i] && (sel_s[i] == DECERR) &&
                           (outst_r[i] == {CntW{1'b0}});
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        carfield_l2_port_sched #(
            .NumReq   (NumReq),
            .IdW      (IdW),
            .MaxOutst (MaxOutst)
        ) u_sched (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .elig_i       (elig_s[p]),
            .gnt_i        (l2_gnt_i[p]),
            .rvalid_i     (l2_rvalid_i[p]),
            .req_o        (port_req_s[p]),
            .win_idx_o    (win_idx_s[p]),
            .win_onehot_o (win_oh_s[p]),
            .full_o       (full_s[p]),
            .pop_valid_o  (pop_valid_s[p]),
            .pop_id_o     (pop_id_s[p])
        );
    end

    // Drive each L2 port from its winner; idle ports present all zeros.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            l2_req_o[p] = port_req_s[p];
            if (port_req_s[p]) begin
                l2_addr_o[p]  = off_s[win_idx_s[p]];
                l2_we_o[p]    = we_i[win_idx_s[p]];
                l2_wdata_o[p] = wdata_i[win_idx_s[p]];
                l2_be_o[p]    = be_i[win_idx_s[p]];
            end else begin
                l2_addr_o[p]  = {AddrWidth{1'b0}};
                l2_we_o[p]    = 1'b0;
                l2_wdata_o[p] = {DataWidth{1'b0}};
                l2_be_o[p]    = {BeWidth{1'b0}};
            end
            port_gnt_s[p] = win_oh_s[p] & {NumReq{port_req_s[p] & l2_gnt_i[p]}};
        end
        gnt_o = port_gnt_s[0] | port_gnt_s[1] | dec_gnt_s;
    end

    // Route popped responses and pending decode errors back to requesters.
    always_comb begin
        resp_hit_s = {(2*NumReq){1'b0}};
        for (int i = 0; i < int'(NumReq); i++) begin
            resp_hit_s[0][i] = pop_valid_s[0] && (pop_id_s[0] == IdW'(i));
            resp_hit_s[1][i] = pop_valid_s[1] && (pop_id_s[1] == IdW'(i));
            out_inc_s[i]     = port_gnt_s[0][i] | port_gnt_s[1][i];
            out_dec_s[i]     = resp_hit_s[0][i] | resp_hit_s[1][i];
            rvalid_o[i]      = out_dec_s[i] | err_pend_r[i];
            err_o[i]         = err_pend_r[i] & ~out_dec_s[i];
            if (resp_hit_s[0][i]) begin
                rdata_o[i] = l2_rdata_i[0];
            end else if (resp_hit_s[1][i]) begin
                rdata_o[i] = l2_rdata_i[1];
            end else begin
                rdata_o[i] = {DataWidth{1'b0}};
            end
        end
    end

    // Per-requester outstanding count, last targeted port and error replies.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outst_r     <= {(NumReq*CntW){1'b0}};
            last_port_r <= {NumReq{1'b0}};
            err_pend_r  <= {NumReq{1'b0}};
        end else begin
            err_pend_r <= dec_gnt_s;
            for (int i = 0; i < int'(NumReq); i++) begin
                case ({out_inc_s[i], out_dec_s[i]})
                    2'b10:   outst_r[i] <= outst_r[i] + {{(CntW-1){1'b0}}, 1'b1};
                    2'b01:   outst_r[i] <= outst_r[i] - {{(CntW-1){1'b0}}, 1'b1};
                    default: outst_r[i] <= outst_r[i];
                endcase
                if (port_gnt_s[1][i]) begin
                    last_port_r[i] <= 1'b1;
                end else if (port_gnt_s[0][i]) begin
                    last_port_r[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_carfield_l2_port_arb.sv
// Directed bench for carfield_l2_port_arb with a response scoreboard.
module tb_carfield_l2_port_arb;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req;
    logic [1:0][31:0]  addr;
    logic [1:0]        we;
    logic [1:0][63:0]  wdata;
    logic [1:0][7:0]   be;
    logic [1:0]        gnt_o;
    logic [1:0]        rvalid_o;
    logic [1:0][63:0]  rdata_o;
    logic [1:0]        err_o;
    logic [1:0]        l2_req_o;
    logic [1:0][31:0]  l2_addr_o;
    logic [1:0]        l2_we_o;
    logic [1:0][63:0]  l2_wdata_o;
    logic [1:0][7:0]   l2_be_o;
    logic [1:0]        l2_gnt;
    logic [1:0]        l2_rvalid;
    logic [1:0][63:0]  l2_rdata;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } resp_t;

    resp_t exp_q0[$];
    resp_t exp_q1[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    carfield_l2_port_arb dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .addr_i      (addr),
        .we_i        (we),
        .wdata_i     (wdata),
        .be_i        (be),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .l2_req_o    (l2_req_o),
        .l2_addr_o   (l2_addr_o),
        .l2_we_o     (l2_we_o),
        .l2_wdata_o  (l2_wdata_o),
        .l2_be_o     (l2_be_o),
        .l2_gnt_i    (l2_gnt),
        .l2_rvalid_i (l2_rvalid),
        .l2_rdata_i  (l2_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [63:0] d, input logic e);
        resp_t r;
        r.data = d;
        r.err  = e;
        if (id == 0) exp_q0.push_back(r);
        else         exp_q1.push_back(r);
    endtask

    task automatic clr();
        req = 2'b00; addr = 64'd0; we = 2'b00; wdata = 128'd0; be = 16'd0;
        l2_gnt = 2'b00; l2_rvalid = 2'b00; l2_rdata = 128'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One L2 response on port p destined for requester id.
    task automatic l2_resp(input int p, input int id, input logic [63:0] d);
        l2_rvalid[p] = 1'b1;
        l2_rdata[p]  = d;
        push_exp(id, d, 1'b0);
        @(negedge clk);
        check($sformatf("resp_present p%0d id%0d", p, id), 64'(rvalid_o[id]), 64'd1);
        cyc();
        l2_rvalid = 2'b00;
        l2_rdata  = 128'd0;
    endtask

    // Monitor: every rvalid_o must match the head of that requester's queue.
    always @(negedge clk) begin : mon
        resp_t e;
        for (int i = 0; i < 2; i++) begin
            if (rvalid_o[i]) begin
                if (((i == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rvalid req%0d: got rdata=%h err=%b, required no response",
                             i, rdata_o[i], err_o[i]);
                end else begin
                    if (i == 0) e = exp_q0.pop_front();
                    else        e = exp_q1.pop_front();
                    check($sformatf("rdata req%0d", i), rdata_o[i], e.data);
                    check($sformatf("err req%0d", i), 64'(err_o[i]), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        // Reset with requests and L2 activity driven: everything stays quiet.
        rst = 1'b1;
        req = 2'b11; addr[0] = 32'h7800_0010; addr[1] = 32'h7820_0020;
        l2_gnt = 2'b11; l2_rvalid = 2'b11; l2_rdata[0] = 64'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset gnt_o", 64'(gnt_o), 64'd0);
        check("reset l2_req_o", 64'(l2_req_o), 64'd0);
        check("reset rvalid_o", 64'(rvalid_o), 64'd0);
        check("reset rdata_o0", rdata_o[0], 64'd0);
        cyc();
        rst = 1'b0;
        clr();
        cyc();

        // Two requesters, two ports, same cycle.
        req = 2'b11; addr[0] = 32'h7800_0010; addr[1] = 32'h7820_0020; l2_gnt = 2'b11;
        @(negedge clk);
        check("dual gnt_o", 64'(gnt_o), 64'd3);
        check("dual l2_req_o", 64'(l2_req_o), 64'd3);
        check("dual l2_addr0", 64'(l2_addr_o[0]), 64'h10);
        check("dual l2_addr1", 64'(l2_addr_o[1]), 64'h20);
        cyc();
        clr();
        l2_rvalid = 2'b11;
        l2_rdata[0] = 64'hAAAA_0000_0000_0011; l2_rdata[1] = 64'hBBBB_0000_0000_0022;
        push_exp(0, 64'hAAAA_0000_0000_0011, 1'b0);
        push_exp(1, 64'hBBBB_0000_0000_0022, 1'b0);
        @(negedge clk);
        check("dual rvalid_o", 64'(rvalid_o), 64'd3);
        cyc();
        clr();

        // Round robin on port 0 from a freshly reset pointer; FIFO fills at 4.
        rst = 1'b1; cyc(); rst = 1'b0;
        req = 2'b11; addr[0] = 32'h7800_0100; addr[1] = 32'h7800_0200; l2_gnt = 2'b01;
        we[0] = 1'b1; wdata[0] = 64'hDEAD_BEEF_0000_0001; be[0] = 8'hF0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rr gnt_o k%0d", k), 64'(gnt_o), (k % 2 == 0) ? 64'd1 : 64'd2);
            check($sformatf("rr l2_addr k%0d", k), 64'(l2_addr_o[0]),
                  (k % 2 == 0) ? 64'h100 : 64'h200);
            if (k == 0) begin
                check("rr l2_we", 64'(l2_we_o[0]), 64'd1);
                check("rr l2_wdata", l2_wdata_o[0], 64'hDEAD_BEEF_0000_0001);
                check("rr l2_be", 64'(l2_be_o[0]), 64'hF0);
            end
            cyc();
        end
        @(negedge clk);
        check("rr fifo full gnt_o", 64'(gnt_o), 64'd0);
        check("rr fifo full l2_req", 64'(l2_req_o), 64'd0);
        cyc();
        clr();
        l2_resp(0, 0, 64'h0000_0000_0000_00D0);
        l2_resp(0, 1, 64'h0000_0000_0000_00D1);
        l2_resp(0, 0, 64'h0000_0000_0000_00D2);
        l2_resp(0, 1, 64'h0000_0000_0000_00D3);

        // Single requester hits the outstanding limit.
        req[0] = 1'b1; addr[0] = 32'h7800_0040; l2_gnt = 2'b01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("outst gnt k%0d", k), 64'(gnt_o), 64'd1);
            cyc();
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("outst blocked k%0d", k), 64'(gnt_o), 64'd0);
            cyc();
        end
        l2_resp(0, 0, 64'h5555_0000_0000_0001);
        @(negedge clk);
        check("outst regrant", 64'(gnt_o), 64'd1);
        cyc();
        clr();
        for (int k = 0; k < 4; k++) l2_resp(0, 0, 64'h5555_0000_0000_0010 + 64'(k));

        // Port switch must wait for the outstanding port-0 response.
        req[0] = 1'b1; addr[0] = 32'h7800_0008; l2_gnt = 2'b11;
        @(negedge clk);
        check("switch first gnt", 64'(gnt_o), 64'd1);
        check("switch first addr", 64'(l2_addr_o[0]), 64'h8);
        cyc();
        addr[0] = 32'h7820_0000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("switch held gnt k%0d", k), 64'(gnt_o), 64'd0);
            check($sformatf("switch held l2_req k%0d", k), 64'(l2_req_o), 64'd0);
            cyc();
        end
        l2_resp(0, 0, 64'h6666_0000_0000_0001);
        @(negedge clk);
        check("switch gnt", 64'(gnt_o), 64'd1);
        check("switch l2_req", 64'(l2_req_o), 64'd2);
        check("switch l2_addr1", 64'(l2_addr_o[1]), 64'h0);
        cyc();
        clr();
        l2_resp(1, 0, 64'h6666_0000_0000_0002);

        // Decode error answered locally one cycle later.
        req[1] = 1'b1; addr[1] = 32'h9000_0000;
        push_exp(1, 64'd0, 1'b1);
        @(negedge clk);
        check("decerr gnt", 64'(gnt_o), 64'd2);
        check("decerr no l2_req", 64'(l2_req_o), 64'd0);
        cyc();
        clr();
        @(negedge clk);
        check("decerr rvalid", 64'(rvalid_o), 64'd2);
        check("decerr err", 64'(err_o), 64'd2);
        cyc();

        // Window boundaries: last byte of each window, first byte outside.
        req = 2'b11; addr[0] = 32'h783F_FFFF; addr[1] = 32'h781F_FFFF; l2_gnt = 2'b11;
        @(negedge clk);
        check("edge gnt", 64'(gnt_o), 64'd3);
        check("edge addr port0", 64'(l2_addr_o[0]), 64'h1F_FFFF);
        check("edge addr port1", 64'(l2_addr_o[1]), 64'h1F_FFFF);
        cyc();
        clr();
        l2_rvalid = 2'b11;
        l2_rdata[0] = 64'h7777_0000_0000_0001; l2_rdata[1] = 64'h7777_0000_0000_0000;
        push_exp(1, 64'h7777_0000_0000_0001, 1'b0);
        push_exp(0, 64'h7777_0000_0000_0000, 1'b0);
        cyc();
        clr();
        req = 2'b11; addr[0] = 32'h77FF_FFFF; addr[1] = 32'h7840_0000;
        push_exp(0, 64'd0, 1'b1);
        push_exp(1, 64'd0, 1'b1);
        @(negedge clk);
        check("outside gnt", 64'(gnt_o), 64'd3);
        check("outside l2_req", 64'(l2_req_o), 64'd0);
        cyc();
        clr();
        @(negedge clk);
        check("outside err", 64'(err_o), 64'd3);
        cyc();

        // Reset with two in flight; late responses must be dropped.
        req[0] = 1'b1; addr[0] = 32'h7800_0000; l2_gnt = 2'b01;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("pre-reset gnt k%0d", k), 64'(gnt_o), 64'd1);
            cyc();
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid reset gnt", 64'(gnt_o), 64'd0);
        check("mid reset l2_req", 64'(l2_req_o), 64'd0);
        cyc();
        rst = 1'b0;
        clr();
        for (int k = 0; k < 2; k++) begin
            l2_rvalid[0] = 1'b1; l2_rdata[0] = 64'hBAD0_0000_0000_0000 + 64'(k);
            @(negedge clk);
            check($sformatf("late rvalid k%0d", k), 64'(rvalid_o), 64'd0);
            check($sformatf("late rdata k%0d", k), rdata_o[0], 64'd0);
            cyc();
        end
        clr();
        req[0] = 1'b1; addr[0] = 32'h7820_0010; l2_gnt = 2'b10;
        @(negedge clk);
        check("post reset port1 gnt", 64'(gnt_o), 64'd1);
        check("post reset l2_addr1", 64'(l2_addr_o[1]), 64'h10);
        cyc();
        clr();
        l2_resp(1, 0, 64'h8888_0000_0000_0001);

        repeat (2) cyc();
        check("queue0 drained", 64'(exp_q0.size()), 64'd0);
        check("queue1 drained", 64'(exp_q1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
